// File: rtl/dm_access_arbiter_pkg.sv
// Shared types and constants for the data-memory access arbiter.
package dm_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } dm_state_e;

  localparam int   DM_WORDS_DEFAULT = 1024;
  localparam logic PORT_CPU         = 1'b0;
  localparam logic PORT_AUX         = 1'b1;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        port;
  } dm_req_t;

endpackage

// File: rtl/dm_access_arbiter_rr.sv
// Two-way pick between the CPU and AUX ports; round-robin or fixed priority.
module rr_arbiter2
  import dm_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output logic       win
);

  logic last_q;

  // On a conflict the port that did not win last time goes first.
  always_comb begin
    win = PORT_CPU;
    if (req == 2'b10)      win = PORT_AUX;
    else if (req == 2'b11) win = (FIXED_PRIO != 0) ? PORT_CPU : ~last_q;
  end

  assign gnt = {accept & win, accept & ~win};

  always_ff @(posedge clk) begin
    if (!reset)      last_q <= PORT_AUX;
    else if (accept) last_q <= win;
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// Sequences one data-memory transaction at a time from two requesters.
// Optional DM_ARB_TRACE_EN prints every committed in-range write.
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter int DM_WORDS   = DM_WORDS_DEFAULT,
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] ADDR_LIMIT = 33'(DM_WORDS) * 33'd4;

  dm_state_e   state_q;
  dm_req_t     req_q, req_d;
  logic [1:0]  rvalid_q, err_q, gnt;
  logic [31:0] rdata0_q, rdata1_q, rd_cap;
  logic        accept, win, in_range, access;

  // Reset low gates the grant and the memory strobes in the same cycle so a
  // transaction cut by reset never touches the memory.
  assign accept   = reset && (state_q == IDLE) && (req0 || req1);
  assign in_range = {1'b0, req_q.addr} < ADDR_LIMIT;
  assign access   = reset && (state_q == ACCESS) && in_range;
  assign rd_cap   = in_range ? mem_rdata : '0;

  rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({req1, req0}),
    .accept (accept),
    .gnt    (gnt),
    .win    (win)
  );

  always_comb begin
    req_d = req_q;
    if (accept) begin
      req_d.port  = win;
      req_d.we    = win ? we1    : we0;
      req_d.addr  = win ? addr1  : addr0;
      req_d.wdata = win ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      req_q    <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= '0;
      err_q    <= '0;
      case (state_q)
        IDLE: if (accept) begin
          state_q <= ACCESS;
          req_q   <= req_d;
        end
        ACCESS: begin
          state_q               <= IDLE;
          rvalid_q[req_q.port]  <= 1'b1;
          err_q[req_q.port]     <= ~in_range;
          // In-range writes leave the port's read data untouched.
          if (!in_range || !req_q.we) begin
            if (req_q.port == PORT_AUX) rdata1_q <= rd_cap;
            else                        rdata0_q <= rd_cap;
          end
        end
      endcase
    end
  end

  assign gnt0      = gnt[0];
  assign gnt1      = gnt[1];
  assign rvalid0   = rvalid_q[0];
  assign rvalid1   = rvalid_q[1];
  assign err0      = err_q[0];
  assign err1      = err_q[1];
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign mem_addr  = {req_q.addr[31:2], 2'b00};
  assign mem_wdata = req_q.wdata;
  assign mem_we    = access & req_q.we;
  assign mem_re    = access & ~req_q.we;

`ifdef DM_ARB_TRACE_EN
  always @(posedge clk) if (mem_we) $display("*%h <= %h", mem_addr, mem_wdata);
`else
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench: round-robin and fixed-priority instances share stimulus; a transaction model checks both every cycle.
module tb_dm_access_arbiter;

  logic clk, reset;
  logic req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;

  logic [1:0]  gnt0_w, gnt1_w, rvalid0_w, rvalid1_w, err0_w, err1_w, mem_we_w, mem_re_w;
  logic [31:0] rdata0_w [0:1];
  logic [31:0] rdata1_w [0:1];
  logic [31:0] mem_addr_w [0:1];
  logic [31:0] mem_wdata_w [0:1];
  logic [31:0] mem_rdata_w [0:1];

  int errs = 0;
  int checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    logic [31:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] <= '0;
    assign mem_rdata_w[k] = mem[mem_addr_w[k][11:2]];
    always @(posedge clk) if (mem_we_w[k]) mem[mem_addr_w[k][11:2]] <= mem_wdata_w[k];

    dm_access_arbiter #(.DM_WORDS(1024), .FIXED_PRIO(k)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0_w[k]), .gnt1(gnt1_w[k]),
      .rvalid0(rvalid0_w[k]), .rvalid1(rvalid1_w[k]),
      .rdata0(rdata0_w[k]), .rdata1(rdata1_w[k]),
      .err0(err0_w[k]), .err1(err1_w[k]),
      .mem_addr(mem_addr_w[k]), .mem_wdata(mem_wdata_w[k]),
      .mem_we(mem_we_w[k]), .mem_re(mem_re_w[k]),
      .mem_rdata(mem_rdata_w[k])
    );
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %h want %h", nm, k, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] xm [0:1][0:1023];
  logic [31:0] m_rd [0:1][0:1];
  logic        m_last [0:1];
  logic        acc_v [0:1], acc_we [0:1], acc_port [0:1];
  logic [31:0] acc_addr [0:1], acc_wd [0:1];
  logic        cmp_v [0:1], cmp_port [0:1], cmp_err [0:1];
  logic [31:0] cmp_rd [0:1];
  logic [31:0] m_addr [0:1], m_wd [0:1];
  logic        armed = 1'b0;
  logic [1:0]  rq, eg;
  logic        w, inr, ewe, ere;

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 1024; i++) xm[k][i] = '0;
      acc_v[k] = 1'b0; cmp_v[k] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      rq = {req1, req0};
      eg = 2'b00;
      w  = 1'b0;
      if (reset && !acc_v[k] && rq != 2'b00) begin
        if (rq == 2'b01)      w = 1'b0;
        else if (rq == 2'b10) w = 1'b1;
        else                  w = (k == 1) ? 1'b0 : ~m_last[k];
        eg[w] = 1'b1;
      end
      inr = acc_addr[k] < 32'h1000;
      ewe = reset && acc_v[k] && acc_we[k] && inr;
      ere = reset && acc_v[k] && !acc_we[k] && inr;
      if (cmp_v[k]) m_rd[k][cmp_port[k]] = cmp_rd[k];

      if (armed) begin
        chk("gnt0", k, 32'(gnt0_w[k]), 32'(eg[0]));
        chk("gnt1", k, 32'(gnt1_w[k]), 32'(eg[1]));
        chk("mem_we", k, 32'(mem_we_w[k]), 32'(ewe));
        chk("mem_re", k, 32'(mem_re_w[k]), 32'(ere));
        chk("mem_addr", k, mem_addr_w[k], m_addr[k]);
        chk("mem_wdata", k, mem_wdata_w[k], m_wd[k]);
        chk("rvalid0", k, 32'(rvalid0_w[k]), 32'(cmp_v[k] && cmp_port[k] == 1'b0));
        chk("rvalid1", k, 32'(rvalid1_w[k]), 32'(cmp_v[k] && cmp_port[k] == 1'b1));
        chk("rdata0", k, rdata0_w[k], m_rd[k][0]);
        chk("rdata1", k, rdata1_w[k], m_rd[k][1]);
        if (cmp_v[k] && cmp_port[k] == 1'b0) chk("err0", k, 32'(err0_w[k]), 32'(cmp_err[k]));
        if (cmp_v[k] && cmp_port[k] == 1'b1) chk("err1", k, 32'(err1_w[k]), 32'(cmp_err[k]));
      end

      cmp_v[k] = 1'b0;
      if (ewe) xm[k][acc_addr[k][11:2]] = acc_wd[k];
      if (reset && acc_v[k]) begin
        cmp_v[k]    = 1'b1;
        cmp_port[k] = acc_port[k];
        cmp_err[k]  = !inr;
        cmp_rd[k]   = !inr ? 32'h0 : acc_we[k] ? m_rd[k][acc_port[k]] : xm[k][acc_addr[k][11:2]];
      end
      acc_v[k] = 1'b0;
      if (eg != 2'b00) begin
        acc_v[k]    = 1'b1;
        acc_port[k] = w;
        acc_we[k]   = w ? we1 : we0;
        acc_addr[k] = w ? addr1 : addr0;
        acc_wd[k]   = w ? wdata1 : wdata0;
        m_last[k]   = w;
        m_addr[k]   = {acc_addr[k][31:2], 2'b00};
        m_wd[k]     = acc_wd[k];
      end
      if (!reset) begin
        acc_v[k] = 1'b0; cmp_v[k] = 1'b0; m_last[k] = 1'b1;
        m_addr[k] = '0; m_wd[k] = '0; m_rd[k][0] = '0; m_rd[k][1] = '0;
      end
    end
    if (!reset) armed = 1'b1;
  end

  // ---------------- directed stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic p, input logic w_i, input logic [31:0] a, input logic [31:0] d);
    if (p) begin req1 = 1'b1; we1 = w_i; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; we0 = w_i; addr0 = a; wdata0 = d; end
    tick;
    req0 = 1'b0; req1 = 1'b0;
    tick;
  endtask

  initial begin
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    tick; tick;

    // 1: first read after reset
    reset = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    @(negedge clk); chk("t1_gnt0", 0, 32'(gnt0_w[0]), 32'd1);
    tick; req0 = 1'b0;
    @(negedge clk); chk("t1_mem_re", 0, 32'(mem_re_w[0]), 32'd1);
    tick;
    @(negedge clk);
    chk("t1_rvalid0", 0, 32'(rvalid0_w[0]), 32'd1);
    chk("t1_rdata0", 0, rdata0_w[0], 32'h0);
    tick;

    // 2: write from port 0, read back on port 1
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("t2_rvalid0", 0, 32'(rvalid0_w[0]), 32'd1);
    chk("t2_err0", 0, 32'(err0_w[0]), 32'd0);
    tick;
    txn(1'b1, 1'b0, 32'h13, 32'h0);
    @(negedge clk);
    chk("t2_rvalid1", 0, 32'(rvalid1_w[0]), 32'd1);
    chk("t2_rdata1", 0, rdata1_w[0], 32'hDEADBEEF);
    chk("t2_err1", 0, 32'(err1_w[0]), 32'd0);
    tick;

    // 3/4: both held; dut0 round-robin, dut1 fixed priority
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'h10; addr1 = 32'h10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t3_rr_gnt0", 0, 32'(gnt0_w[0]), 32'(i == 0 || i == 4));
      chk("t3_rr_gnt1", 0, 32'(gnt1_w[0]), 32'(i == 2 || i == 6));
      chk("t4_fp_gnt0", 1, 32'(gnt0_w[1]), 32'(i % 2 == 0));
      chk("t4_fp_gnt1", 1, 32'(gnt1_w[1]), 32'd0);
      tick;
    end
    req0 = 1'b0;
    @(negedge clk); chk("t4_fp_gnt1_after", 1, 32'(gnt1_w[1]), 32'd1);
    tick; req1 = 1'b0;
    tick; tick;

    // 5: out-of-range write must not alias onto word 0; top word is in range
    txn(1'b0, 1'b1, 32'h0, 32'hA5A5A5A5);
    tick;
    txn(1'b1, 1'b1, 32'h1000, 32'h12345678);
    @(negedge clk);
    chk("t5_rvalid1", 0, 32'(rvalid1_w[0]), 32'd1);
    chk("t5_err1", 0, 32'(err1_w[0]), 32'd1);
    chk("t5_rdata1", 0, rdata1_w[0], 32'h0);
    tick;
    txn(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("t5_rdata0", 0, rdata0_w[0], 32'hA5A5A5A5);
    chk("t5_err0", 0, 32'(err0_w[0]), 32'd0);
    tick;
    txn(1'b1, 1'b1, 32'hFFC, 32'h0BADF00D);
    tick;
    txn(1'b1, 1'b0, 32'hFFC, 32'h0);
    @(negedge clk);
    chk("t5_top_rdata1", 1, rdata1_w[1], 32'h0BADF00D);
    chk("t5_top_err1", 1, 32'(err1_w[1]), 32'd0);
    tick;

    // 6: reset during the ACCESS cycle of a write
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'hCAFEF00D;
    tick;
    req0 = 1'b0; reset = 1'b0;
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rvalid0", 0, 32'(rvalid0_w[0]), 32'd0);
    chk("t6_rdata0", 0, rdata0_w[0], 32'h0);
    chk("t6_mem_addr", 0, mem_addr_w[0], 32'h0);
    chk("t6_mem_wdata", 0, mem_wdata_w[0], 32'h0);
    tick;
    txn(1'b0, 1'b0, 32'h20, 32'h0);
    @(negedge clk);
    chk("t6_read_rvalid0", 0, 32'(rvalid0_w[0]), 32'd1);
    chk("t6_read_rdata0", 0, rdata0_w[0], 32'h0);
    tick; tick;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
